// File: rtl/tdm_demux_1x4.sv
// Purpose: splits a framed TDM sample stream into four channels and publishes each complete frame atomically.
// Latency: a..d and frame_valid update on the clock edge that accepts the slot-3 beat, so they are visible 1 clock after it.
// Backpressure: none. Beats are taken whenever din_valid is high, and the block holds all state while din_valid is low.
module tdm_demux_1x4 #(
    parameter int WIDTH       = 1,
    parameter int STRICT_SYNC = 0,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             frame_valid,
    output logic             locked,
    output logic [1:0]       slot,
    output logic             sync_err,
    output logic [CNT_W-1:0] frame_cnt
);

    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [1:0]       slot_nxt;
    logic [WIDTH-1:0] shadow0, shadow1, shadow2;
    logic [WIDTH-1:0] shadow0_nxt, shadow1_nxt, shadow2_nxt;
    logic [WIDTH-1:0] a_nxt, b_nxt, c_nxt, d_nxt;
    logic             frame_valid_nxt, sync_err_nxt;
    logic [CNT_W-1:0] frame_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            locked      <= 1'b0;
            slot        <= 2'd0;
            shadow0     <= '0;
            shadow1     <= '0;
            shadow2     <= '0;
            a           <= '0;
            b           <= '0;
            c           <= '0;
            d           <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            locked      <= (state_nxt == LOCKED);
            slot        <= slot_nxt;
            shadow0     <= shadow0_nxt;
            shadow1     <= shadow1_nxt;
            shadow2     <= shadow2_nxt;
            a           <= a_nxt;
            b           <= b_nxt;
            c           <= c_nxt;
            d           <= d_nxt;
            frame_valid <= frame_valid_nxt;
            sync_err    <= sync_err_nxt;
            frame_cnt   <= frame_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        slot_nxt        = slot;
        shadow0_nxt     = shadow0;
        shadow1_nxt     = shadow1;
        shadow2_nxt     = shadow2;
        a_nxt           = a;
        b_nxt           = b;
        c_nxt           = c;
        d_nxt           = d;
        frame_valid_nxt = 1'b0;
        sync_err_nxt    = 1'b0;
        frame_cnt_nxt   = frame_cnt;
        if (din_valid) begin
            case (state)
                HUNT: begin
                    if (frame_sync) begin
                        shadow0_nxt = din;
                        slot_nxt    = 2'd1;
                        state_nxt   = LOCKED;
                    end
                end
                LOCKED: begin
                    // An early sync restarts the frame. It takes priority over completing slot 3.
                    if (frame_sync && slot != 2'd0) begin
                        sync_err_nxt = 1'b1;
                        shadow0_nxt  = din;
                        slot_nxt     = 2'd1;
                    end else if (slot == 2'd0) begin
                        if (!frame_sync && STRICT_SYNC != 0) begin
                            sync_err_nxt = 1'b1;
                            state_nxt    = HUNT;
                            slot_nxt     = 2'd0;
                        end else begin
                            shadow0_nxt = din;
                            slot_nxt    = 2'd1;
                        end
                    end else if (slot == 2'd3) begin
                        a_nxt           = shadow0;
                        b_nxt           = shadow1;
                        c_nxt           = shadow2;
                        d_nxt           = din;
                        frame_valid_nxt = 1'b1;
                        frame_cnt_nxt   = frame_cnt + CNT_W'(1);
                        slot_nxt        = 2'd0;
                    end else begin
                        if (slot == 2'd1) shadow1_nxt = din;
                        else              shadow2_nxt = din;
                        slot_nxt = slot + 2'd1;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

endmodule
